// File: rtl/i281_pkg.sv
// Shared encodings and widths for the i281 run-control block.
package i281_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_RUN    = 2'd1,
    MODE_STEP   = 2'd2,
    MODE_HALTED = 2'd3
  } mode_t;

  localparam int EN_CNT_W   = 16;
  localparam int STAB_CNT_W = 16;

endpackage

// File: rtl/i281_run_control_if.sv
// Board/CPU-facing signal bundle of the run controller.
interface i281_run_control_if;
  import i281_pkg::*;

  logic                run_sw;
  logic                step_btn;
  logic                halt_req;
  logic                cpu_en;
  logic [1:0]          mode;
  logic [EN_CNT_W-1:0] en_count;

  modport master (
    output run_sw, step_btn, halt_req,
    input  cpu_en, mode, en_count
  );

  modport slave (
    input  run_sw, step_btn, halt_req,
    output cpu_en, mode, en_count
  );

endinterface

// File: rtl/i281_debouncer.sv
// Two-flop synchronizer followed by a stability-counter debouncer.
module i281_debouncer
  import i281_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic db
);

  localparam logic [STAB_CNT_W-1:0] LAST_CNT = STAB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                  sync_p0;
  logic                  sync_p1;
  logic [STAB_CNT_W-1:0] stab_cnt;
  logic                  db_q;

  // Stage p0/p1: metastability guard on the raw board level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // The output flips on the cycle the mismatch run reaches DEBOUNCE_CYCLES.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stab_cnt <= '0;
      db_q     <= 1'b0;
    end else if (sync_p1 != db_q) begin
      if (stab_cnt == LAST_CNT) begin
        stab_cnt <= '0;
        db_q     <= sync_p1;
      end else begin
        stab_cnt <= stab_cnt + 1'b1;
      end
    end else begin
      stab_cnt <= '0;
    end
  end

  assign db = db_q;

endmodule

// File: rtl/i281_run_control.sv
// Run/step/halt sequencer that produces the i281 CPU clock-enable.
module i281_run_control
  import i281_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clock,
  input  logic               reset,
  i281_run_control_if.slave  bus
);

  logic                run_db;
  logic                step_db;
  logic                step_db_q;
  logic                step_rise;
  mode_t               state_q;
  mode_t               state_d;
  logic                cpu_en_q;
  logic [EN_CNT_W-1:0] en_count_q;

  function automatic logic [EN_CNT_W-1:0] sat_inc(input logic [EN_CNT_W-1:0] v);
    return (v == {EN_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  i281_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clock (clock),
    .reset (reset),
    .raw   (bus.run_sw),
    .db    (run_db)
  );

  i281_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clock (clock),
    .reset (reset),
    .raw   (bus.step_btn),
    .db    (step_db)
  );

  // Edge history is tracked in every state, so presses outside IDLE are dropped.
  assign step_rise = step_db & ~step_db_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MODE_IDLE: begin
        if (run_db)         state_d = MODE_RUN;
        else if (step_rise) state_d = MODE_STEP;
      end
      MODE_RUN: begin
        if (bus.halt_req)   state_d = MODE_HALTED;
        else if (!run_db)   state_d = MODE_IDLE;
      end
      MODE_STEP: begin
        state_d = bus.halt_req ? MODE_HALTED : MODE_IDLE;
      end
      MODE_HALTED: begin
        if (!run_db && !step_db) state_d = MODE_IDLE;
      end
      default: state_d = MODE_IDLE;
    endcase
  end

  // Enable is registered from the next state so it tracks mode edge-for-edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= MODE_IDLE;
      cpu_en_q   <= 1'b0;
      step_db_q  <= 1'b0;
      en_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cpu_en_q   <= (state_d == MODE_RUN) || (state_d == MODE_STEP);
      step_db_q  <= step_db;
      if (cpu_en_q) en_count_q <= sat_inc(en_count_q);
    end
  end

  assign bus.cpu_en   = cpu_en_q;
  assign bus.mode     = state_q;
  assign bus.en_count = en_count_q;

endmodule

// File: tb/tb_i281_run_control.sv
// Self-checking bench for i281_run_control with a window-based debounce model.
module tb_i281_run_control;

  localparam int N = 4;

  logic clock;
  logic reset;
  i281_run_control_if bus();

  i281_run_control #(.DEBOUNCE_CYCLES(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: mode 0 IDLE, 1 RUN, 2 STEP, 3 HALTED.
  int m_mode;
  bit m_cpu_en;
  int m_count;
  bit m_run_db, m_step_db, m_step_prev;
  bit run_hist[$];
  bit step_hist[$];

  task automatic model_reset();
    m_mode = 0; m_cpu_en = 0; m_count = 0;
    m_run_db = 0; m_step_db = 0; m_step_prev = 0;
    run_hist.delete(); step_hist.delete();
    for (int i = 0; i <= N + 1; i++) begin
      run_hist.push_back(1'b0);
      step_hist.push_back(1'b0);
    end
  endtask

  // A debounced level flips once the N synchronized samples before it all disagree.
  function automatic bit flip_due(input bit h[$], input bit db);
    for (int i = 1; i <= N; i++)
      if (h[i] == db) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    int nm;
    bit rise, halt;
    nm   = m_mode;
    rise = m_step_db && !m_step_prev;
    halt = bus.halt_req;
    case (m_mode)
      0: if (m_run_db) nm = 1; else if (rise) nm = 2;
      1: if (halt) nm = 3; else if (!m_run_db) nm = 0;
      2: nm = halt ? 3 : 0;
      default: if (!m_run_db && !m_step_db) nm = 0;
    endcase
    if (m_cpu_en && m_count < 65535) m_count++;
    m_step_prev = m_step_db;
    if (flip_due(run_hist, m_run_db))   m_run_db  = !m_run_db;
    if (flip_due(step_hist, m_step_db)) m_step_db = !m_step_db;
    run_hist.push_front(bus.run_sw);    void'(run_hist.pop_back());
    step_hist.push_front(bus.step_btn); void'(step_hist.pop_back());
    m_mode   = nm;
    m_cpu_en = (nm == 1) || (nm == 2);
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) model_step();
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic exp_en;
    bus.run_sw = 1'b1; bus.step_btn = 1'b0; bus.halt_req = 1'b0;
    reset = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (bus.cpu_en !== 1'b0 || bus.mode !== 2'd0 || bus.en_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_state: cpu_en=%0b mode=%0d en_count=%0d, expected 0/0/0",
               bus.cpu_en, bus.mode, bus.en_count);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_en = (e >= 7);
      vectors++;
      if (bus.cpu_en !== exp_en) begin
        miscompares++;
        $display("FAIL reset_release_latency edge %0d: cpu_en=%0b expected %0b", e, bus.cpu_en, exp_en);
      end
    end
    vectors++;
    if (bus.mode !== 2'd1) begin
      miscompares++;
      $display("FAIL reset_release_mode: mode=%0d expected 1", bus.mode);
    end
  endtask

  task automatic test_async_reset();
    logic exp_en;
    repeat (5) tick();
    #5 reset = 1'b0;
    #1;
    vectors++;
    if (bus.cpu_en !== 1'b0 || bus.en_count !== 16'd0 || bus.mode !== 2'd0) begin
      miscompares++;
      $display("FAIL async_reset: cpu_en=%0b en_count=%0d mode=%0d, expected 0/0/0",
               bus.cpu_en, bus.en_count, bus.mode);
    end
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_en = (e >= 7);
      vectors++;
      if (bus.cpu_en !== exp_en) begin
        miscompares++;
        $display("FAIL reset_reentry edge %0d: cpu_en=%0b expected %0b", e, bus.cpu_en, exp_en);
      end
    end
  endtask

  task automatic test_step();
    int pulses;
    logic [15:0] cnt0;
    bus.run_sw = 1'b0;
    for (int i = 0; i < 20 && bus.mode !== 2'd0; i++) tick();
    vectors++;
    if (bus.mode !== 2'd0) begin
      miscompares++;
      $display("FAIL step_enter_idle: mode=%0d expected 0", bus.mode);
    end
    cnt0 = bus.en_count;
    pulses = 0;
    bus.step_btn = 1'b1;
    repeat (10) begin tick(); if (bus.cpu_en === 1'b1) pulses++; end
    bus.step_btn = 1'b0;
    repeat (10) begin tick(); if (bus.cpu_en === 1'b1) pulses++; end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL step_pulse_count: pulses=%0d expected 1", pulses);
    end
    vectors++;
    if (bus.en_count !== cnt0 + 16'd1) begin
      miscompares++;
      $display("FAIL step_en_count: en_count=%0d expected %0d", bus.en_count, cnt0 + 16'd1);
    end
    vectors++;
    if (bus.mode !== 2'd0) begin
      miscompares++;
      $display("FAIL step_return_idle: mode=%0d expected 0", bus.mode);
    end
  endtask

  task automatic test_glitch();
    bit seen_en, seen_mode;
    seen_en = 0; seen_mode = 0;
    bus.run_sw = 1'b1;
    repeat (3) begin tick(); if (bus.cpu_en !== 1'b0) seen_en = 1; if (bus.mode !== 2'd0) seen_mode = 1; end
    bus.run_sw = 1'b0;
    repeat (15) begin tick(); if (bus.cpu_en !== 1'b0) seen_en = 1; if (bus.mode !== 2'd0) seen_mode = 1; end
    vectors++;
    if (seen_en) begin
      miscompares++;
      $display("FAIL glitch_cpu_en: cpu_en=1 seen, expected 0 throughout");
    end
    vectors++;
    if (seen_mode) begin
      miscompares++;
      $display("FAIL glitch_mode: mode left 0, expected 0 throughout");
    end
  endtask

  task automatic test_halt();
    bit seen_en;
    bus.run_sw = 1'b1;
    for (int i = 0; i < 20 && bus.mode !== 2'd1; i++) tick();
    vectors++;
    if (bus.mode !== 2'd1) begin
      miscompares++;
      $display("FAIL halt_enter_run: mode=%0d expected 1", bus.mode);
    end
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    vectors++;
    if (bus.cpu_en !== 1'b0 || bus.mode !== 2'd3) begin
      miscompares++;
      $display("FAIL halt_entry: cpu_en=%0b mode=%0d expected 0/3", bus.cpu_en, bus.mode);
    end
    seen_en = 0;
    bus.step_btn = 1'b1;
    repeat (10) begin tick(); if (bus.cpu_en !== 1'b0) seen_en = 1; end
    bus.step_btn = 1'b0;
    repeat (10) begin tick(); if (bus.cpu_en !== 1'b0) seen_en = 1; end
    vectors++;
    if (seen_en || bus.mode !== 2'd3) begin
      miscompares++;
      $display("FAIL halt_step_ignored: pulse_seen=%0b mode=%0d expected 0/3", seen_en, bus.mode);
    end
    bus.run_sw = 1'b0;
    for (int i = 0; i < 20 && bus.mode !== 2'd0; i++) tick();
    vectors++;
    if (bus.mode !== 2'd0) begin
      miscompares++;
      $display("FAIL halt_exit: mode=%0d expected 0", bus.mode);
    end
  endtask

  task automatic test_random();
    int run_hold, step_hold;
    run_hold = 0; step_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (run_hold == 0) begin
        bus.run_sw = 1'($urandom_range(0, 1));
        run_hold   = $urandom_range(1, 12);
      end
      if (step_hold == 0) begin
        bus.step_btn = 1'($urandom_range(0, 1));
        step_hold    = $urandom_range(1, 10);
      end
      run_hold--; step_hold--;
      bus.halt_req = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
      end
      tick();
      vectors++;
      if (bus.mode !== 2'(m_mode) || bus.cpu_en !== m_cpu_en || bus.en_count !== 16'(m_count)) begin
        miscompares++;
        $display("FAIL random cycle %0d: mode=%0d cpu_en=%0b en_count=%0d expected %0d/%0b/%0d",
                 c, bus.mode, bus.cpu_en, bus.en_count, m_mode, m_cpu_en, m_count);
      end
    end
    bus.run_sw = 1'b0; bus.step_btn = 1'b0; bus.halt_req = 1'b0;
  endtask

  task automatic test_saturation();
    reset = 1'b0;
    model_reset();
    bus.run_sw = 1'b1; bus.step_btn = 1'b0; bus.halt_req = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 20 && bus.mode !== 2'd1; i++) tick();
    repeat (65540) tick();
    vectors++;
    if (bus.en_count !== 16'hFFFF || m_count != 65535) begin
      miscompares++;
      $display("FAIL saturation: en_count=%0h model=%0h expected ffff", bus.en_count, m_count);
    end
    tick();
    vectors++;
    if (bus.en_count !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL saturation_hold: en_count=%0h expected ffff", bus.en_count);
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_step();
    test_glitch();
    test_halt();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i281_run_control.md
I281_RUN_CONTROL -- requirements
Module: i281_run_control

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive stable synchronized samples required before a debounced input changes; legal range 1..65535.
REQ-002 clock  input  1  single system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 run_sw  input  1  raw, asynchronous run switch level from the board.
REQ-005 step_btn  input  1  raw, asynchronous single-step pushbutton.
REQ-006 halt_req  input  1  synchronous halt request from the CPU; high when a halt is executed.
REQ-007 cpu_en  output  1  registered CPU clock-enable consumed by i281_toplevel as its run input.
REQ-008 mode  output  2  registered FSM state: 0 IDLE, 1 RUN, 2 STEP, 3 HALTED.
REQ-009 en_count  output  16  registered count of cycles with cpu_en high, saturating.

Function
REQ-010 run_sw and step_btn each pass through a two-flop synchronizer, then a debouncer.
REQ-011 A debounced output toggles only when the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle clears the stability counter.
REQ-012 Latency: debounced value changes on the (2+DEBOUNCE_CYCLES)th rising edge after the edge that first samples the new raw level; glitches shorter than DEBOUNCE_CYCLES cycles are suppressed.
REQ-013 IDLE: cpu_en=0; debounced run high -> RUN; rising edge of debounced step (while run low) -> STEP.
REQ-014 RUN: cpu_en=1 every cycle; debounced run low -> IDLE; halt_req=1 -> HALTED (halt takes priority over run low).
REQ-015 STEP: cpu_en=1 for exactly one cycle, then -> IDLE unconditionally, or -> HALTED if halt_req=1 in that cycle.
REQ-016 HALTED: cpu_en=0; leaves only when debounced run is low and debounced step is low -> IDLE.
REQ-017 cpu_en and mode are registered from the next state: cpu_en rises on the same edge the FSM enters RUN/STEP and falls on the edge it leaves.
REQ-018 A step edge arriving while in RUN or HALTED is ignored, not queued.
REQ-019 en_count increments on each edge at which cpu_en is 1, saturating at 16'hFFFF (no wrap).
REQ-020 halt_req outside RUN/STEP has no effect.

Reset
REQ-021 Reset assertion asynchronously forces mode=IDLE, cpu_en=0, en_count=0, synchronizer flops=0, debounced values=0, stability counters=0.
REQ-022 Reset mid-RUN drops cpu_en immediately (no clock needed); after release, a run_sw still held high re-enters RUN only after the full REQ-012 debounce latency.

Structure
REQ-023 Package i281_pkg holds the mode state encoding (IDLE/RUN/STEP/HALTED) and the en_count width constant.
REQ-024 One sub-module, i281_debouncer (synchronizer + stability counter, parameterized by DEBOUNCE_CYCLES), instantiated twice.
REQ-025 Stability counter width is 16 bits regardless of parameter value.

Verification (DEBOUNCE_CYCLES=4, clock period 20 ns)
REQ-026 reset=0 with run_sw=1 held; release reset -> cpu_en 0 for 6 edges, 1 from 7th edge; mode=1.
REQ-027 In IDLE, step_btn high 10 cycles -> exactly one cpu_en pulse of one cycle; en_count increments by 1; mode returns to 0.
REQ-028 run_sw glitch high for 3 cycles -> cpu_en stays 0, mode stays 0.
REQ-029 In RUN, pulse halt_req one cycle -> cpu_en 0 next edge, mode=3; then step_btn press -> no pulse; run_sw low (debounced) -> mode=0.
REQ-030 Preload-free saturation: run 65540 cycles in RUN -> en_count holds 16'hFFFF.
REQ-031 Assert reset mid-RUN between clock edges -> cpu_en and en_count go 0 before next edge.
